dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU. It accepts one load or store request at a time from the MEM stage over a req/ready handshake, waits a configurable latency, and completes the access with a one-cycle acknowledge carrying read data or an error flag. The CPU's MEM stage drives the requests and stalls until the acknowledge. The responder replaces the single-cycle Data_Memory on that path.

## Interface
Parameters:
- DEPTH_WORDS, default 256: number of 32-bit words; must be a power of two, ≥ 2.
- LATENCY, default 4: edges from request acceptance to the response edge; legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous active-high reset.
- req_i, input, 1: request valid from the MEM stage.
- we_i, input, 1: 1 = store (write), 0 = load (read).
- addr_i, input, 32: byte address.
- wdata_i, input, 32: store data.
- ready_o, output, 1: responder can accept a request this cycle.
- ack_o, output, 1: one-cycle completion pulse.
- err_o, output, 1: completion is an error; valid only while ack_o = 1.
- rdata_o, output, 32: load data; valid while ack_o = 1 for a non-error load.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - ready_o = (state == IDLE).
  - ack_o = (state == RESP).
- IDLE:
  - On an edge with req_i = 1, capture we_i, addr_i and wdata_i into request registers.
  - Load counter cnt = LATENCY-1 and go to WAIT.
  - With req_i = 0, stay in IDLE.
- WAIT:
  - If cnt ≠ 0: decrement cnt and stay in WAIT.
  - If cnt = 0: perform the access at this edge and go to RESP.
- RESP: lasts exactly one cycle, then return to IDLE unconditionally. req_i is ignored in RESP.
- Access rules, applied to the captured request:
  - Error when addr[1:0] ≠ 0 or addr ≥ 4·DEPTH_WORDS. On error: err_o = 1, rdata_o = 0, no array write.
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store: write the word, err_o = 0, rdata_o = 0.
  - Load: rdata_o = array[index], err_o = 0.
- Inputs are sampled only at the accept edge. Later changes to addr_i, wdata_i and we_i have no effect on the request in flight.
- The memory array is not cleared by reset; the bench preloads it via hierarchical access.
- Only one request is in flight at a time. There is no queuing.

## Timing
- Reset values after any edge with rst_i = 1:
  - state = IDLE, cnt = 0.
  - ready_o = 1, ack_o = 0, err_o = 0, rdata_o = 0.
- Reset during WAIT aborts the request: no array write, no ack_o.
- rst_i has priority over req_i at the same edge; that request is not accepted.
- Latency:
  - Request accepted at edge k.
  - Array write (stores) and rdata_o/err_o registration happen at edge k+LATENCY.
  - ack_o is high for the cycle after edge k+LATENCY.
  - ready_o rises after edge k+LATENCY+1.
- Minimum request interval is LATENCY+2 edges: the next accept is earliest at edge k+LATENCY+2.
- LATENCY = 1: WAIT lasts one cycle and RESP follows at edge k+1.
- rdata_o and err_o hold their values until the next RESP entry or reset.
- The bench must not check them outside ack_o = 1.
- Store-then-load to the same address: the load returns the new data, because the write commits before the next accept.

## Test plan
- Reset, then idle: rst_i = 1 for 2 edges, release → ready_o = 1, ack_o = 0, rdata_o = 0; no ack_o for 10 idle cycles.
- Load latency: preload word 5 = 0xDEADBEEF; LATENCY = 4; load addr 0x14 accepted at edge k → ack_o high only after edge k+4, rdata_o = 0xDEADBEEF, err_o = 0; ready_o low from k to k+5.
- Store then load: store 0x12345678 to 0x20, then load 0x20 at the first ready_o → second ack returns 0x12345678; accepts are exactly LATENCY+2 edges apart.
- Errors: load 0x22 (misaligned) → ack with err_o = 1, rdata_o = 0. Store to 0x400 with DEPTH_WORDS = 256 → err_o = 1, and the array is unchanged (word 0 still holds its preload).
- Input stability: change addr_i and wdata_i every cycle after a store is accepted to 0x08 with data 0xA5A5A5A5 → word 2 = 0xA5A5A5A5; no other word is modified.
- Reset mid-operation: store 0xFFFFFFFF to 0x0C, assert rst_i at accept edge+2 → no ack_o, word 3 unchanged, ready_o = 1 after the reset edge. Repeat with LATENCY = 1 → ack_o one edge after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, fixed LATENCY
// from accept to the response edge, one-cycle ack carrying read data or error.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           mem_we_s;
    logic           acc_err_s;
    logic [AW-1:0]  idx_s;

    logic [31:0]    mem [DEPTH_WORDS];

    // Decode the captured address: word index and out-of-range/misaligned error.
    always_comb begin
        idx_s     = addr_q[AW+1:2];
        acc_err_s = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
    end

    // Next-state and access logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_RESP;
                    if (acc_err_s) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (we_q) begin
                        mem_we_s = 1'b1;
                        err_d    = 1'b0;
                        rdata_d  = 32'd0;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = mem[idx_s];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array is never cleared; a reset on the access edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (mem_we_s && !rst_i) begin
            mem[idx_s] <= wdata_q;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign ack_o   = (state_q == ST_RESP);
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule
